// File: rtl/fa_response_checker_if.sv
// Handshake bundle between a full-adder stimulus driver and its response checker.
// The master drives operands and DUT results; the slave reports the check results.
interface fa_response_checker_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             cin;
    logic             s;
    logic             cout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [7:0]       cov_map;
    logic             cov_full;
    logic             err;
    logic [4:0]       first_fail;

    modport master (
        output start, stop, in_valid, a, b, cin, s, cout,
        input  busy, done, pass_cnt, fail_cnt, cov_map, cov_full, err, first_fail
    );

    modport slave (
        input  start, stop, in_valid, a, b, cin, s, cout,
        output busy, done, pass_cnt, fail_cnt, cov_map, cov_full, err, first_fail
    );
endinterface

// File: rtl/fa_response_checker.sv
// Self-checking monitor for a full adder: aligns each DUT result with its operands,
// compares against a+b+cin, and keeps counters, coverage and the first failing vector.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting vectors and checking results
// DRAIN | no new vectors; in-flight results still checked for LATENCY cycles
// DONE  | results frozen until the next start
module fa_response_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    fa_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [2:0]       DRAIN_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_nxt;
    logic [2:0]       drain_cnt, drain_nxt;
    logic             accept;
    logic [3:0]       stage_in;
    logic             chk_v;
    logic [2:0]       chk_vec;
    logic             check_en;
    logic [1:0]       exp_sum;
    logic             match;
    logic [7:0]       cov_bit;
    logic [CNT_W-1:0] pass_q, fail_q;
    logic [7:0]       cov_q;
    logic             cov_full_q;
    logic             err_q;
    logic [4:0]       first_fail_q;

    // Vectors presented in the start or stop cycle are not part of the run.
    assign accept   = (state == RUN) && bus.in_valid && !bus.stop && !bus.start;
    assign stage_in = {accept, bus.a, bus.b, bus.cin};

    generate
        if (LATENCY == 0) begin : g_direct
            assign chk_v   = stage_in[3];
            assign chk_vec = stage_in[2:0];
        end else begin : g_pipe
            logic [3:0] pipe [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else if (bus.start) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= stage_in;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign chk_v   = pipe[LATENCY-1][3];
            assign chk_vec = pipe[LATENCY-1][2:0];
        end
    endgenerate

    assign check_en = chk_v && ((state == RUN) || (state == DRAIN)) && !bus.start;
    assign exp_sum  = {1'b0, chk_vec[2]} + {1'b0, chk_vec[1]} + {1'b0, chk_vec[0]};
    assign match    = ({bus.cout, bus.s} == exp_sum);
    assign cov_bit  = 8'd1 << chk_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end else if (bus.stop) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (bus.start)           state_nxt = RUN;
                else if (drain_cnt == 0) state_nxt = DONE;
                else                     drain_nxt = drain_cnt - 3'd1;
            end
            DONE: if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q       <= '0;
            fail_q       <= '0;
            cov_q        <= '0;
            cov_full_q   <= 1'b0;
            err_q        <= 1'b0;
            first_fail_q <= '0;
        end else if (bus.start) begin
            pass_q       <= '0;
            fail_q       <= '0;
            cov_q        <= '0;
            cov_full_q   <= 1'b0;
            err_q        <= 1'b0;
            first_fail_q <= '0;
        end else if (check_en) begin
            cov_q      <= cov_q | cov_bit;
            cov_full_q <= &(cov_q | cov_bit);
            if (match) begin
                if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_W'(1);
            end else begin
                if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_W'(1);
                if (!err_q) begin
                    err_q        <= 1'b1;
                    first_fail_q <= {chk_vec, bus.cout, bus.s};
                end
            end
        end
    end

    assign bus.busy       = (state == RUN) || (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.pass_cnt   = pass_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.cov_map    = cov_q;
    assign bus.cov_full   = cov_full_q;
    assign bus.err        = err_q;
    assign bus.first_fail = first_fail_q;
endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: two instances (LATENCY=1/CNT_W=16 and LATENCY=4/CNT_W=3)
// share one stimulus stream; a scoreboard queue per instance predicts every result.
module tb_fa_response_checker;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;
    localparam int MAX0 = 65535;
    localparam int MAX1 = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fa_response_checker_if #(.CNT_W(16)) bus0 ();
    fa_response_checker_if #(.CNT_W(3))  bus1 ();

    fa_response_checker #(.LATENCY(LAT0), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fa_response_checker #(.LATENCY(LAT1), .CNT_W(3))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int         due;
        logic [2:0] vec;
        logic [1:0] got;
    } entry_t;

    typedef struct packed {
        logic       v;
        logic [2:0] vec;
        logic [1:0] got;
    } hist_t;

    entry_t     q0[$];
    entry_t     q1[$];
    hist_t      hist[5];
    int         nchecks = 0;
    int         nerrs   = 0;
    int         cyc     = 0;
    bit         in_run  = 0;
    bit         force_c0 = 0;
    int         exp_pass[2];
    int         exp_fail[2];
    logic [7:0] exp_cov[2];
    logic       exp_err[2];
    logic [4:0] exp_ff[2];
    logic [2:0] seq[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerrs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_pass[d] = 0;
            exp_fail[d] = 0;
            exp_cov[d]  = '0;
            exp_err[d]  = 1'b0;
            exp_ff[d]   = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic apply(input int d, input entry_t e);
        logic [1:0] sum;
        int         maxc;
        sum  = {1'b0, e.vec[2]} + {1'b0, e.vec[1]} + {1'b0, e.vec[0]};
        maxc = (d == 0) ? MAX0 : MAX1;
        if (e.got == sum) begin
            if (exp_pass[d] < maxc) exp_pass[d]++;
        end else begin
            if (exp_fail[d] < maxc) exp_fail[d]++;
            if (!exp_err[d]) begin
                exp_err[d] = 1'b1;
                exp_ff[d]  = {e.vec, e.got};
            end
        end
        exp_cov[d][e.vec] = 1'b1;
    endtask

    task automatic check_results();
        chk("pass0", bus0.pass_cnt, exp_pass[0]);
        chk("fail0", bus0.fail_cnt, exp_fail[0]);
        chk("cov0", bus0.cov_map, exp_cov[0]);
        chk("covfull0", bus0.cov_full, exp_cov[0] == 8'hFF);
        chk("err0", bus0.err, exp_err[0]);
        chk("ff0", bus0.first_fail, exp_ff[0]);
        chk("pass1", bus1.pass_cnt, exp_pass[1]);
        chk("fail1", bus1.fail_cnt, exp_fail[1]);
        chk("cov1", bus1.cov_map, exp_cov[1]);
        chk("covfull1", bus1.cov_full, exp_cov[1] == 8'hFF);
        chk("err1", bus1.err, exp_err[1]);
        chk("ff1", bus1.first_fail, exp_ff[1]);
    endtask

    task automatic drive_idle();
        bus0.start = 0; bus0.stop = 0; bus0.in_valid = 0;
        bus1.start = 0; bus1.stop = 0; bus1.in_valid = 0;
    endtask

    // One clock: drive inputs and the modelled DUT response, then score after the edge.
    task automatic step(input bit st, input bit sp, input bit v, input logic [2:0] vec);
        logic [1:0] good;
        logic [1:0] got;
        bit         acc;
        good = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
        got  = force_c0 ? {1'b0, good[0]} : good;
        acc  = in_run && v && !sp && !st;
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {acc, vec, got};
        bus0.start = st; bus0.stop = sp; bus0.in_valid = v;
        bus1.start = st; bus1.stop = sp; bus1.in_valid = v;
        {bus0.a, bus0.b, bus0.cin} = vec;
        {bus1.a, bus1.b, bus1.cin} = vec;
        {bus0.cout, bus0.s} = hist[LAT0].v ? hist[LAT0].got : 2'($urandom_range(0, 3));
        {bus1.cout, bus1.s} = hist[LAT1].v ? hist[LAT1].got : 2'($urandom_range(0, 3));
        if (acc) begin
            q0.push_back('{cyc + 1 + LAT0, vec, got});
            q1.push_back('{cyc + 1 + LAT1, vec, got});
        end
        @(posedge clk);
        cyc++;
        #1;
        drive_idle();
        if (st) begin
            clear_model();
            in_run = 1;
        end else if (sp) begin
            in_run = 0;
        end
        while (q0.size() > 0 && q0[0].due == cyc) apply(0, q0.pop_front());
        while (q1.size() > 0 && q1[0].due == cyc) apply(1, q1.pop_front());
        check_results();
    endtask

    task automatic run_seq(input bit gapped);
        for (int i = 0; i < 8; i++) begin
            if (gapped) repeat ($urandom_range(0, 3)) step(0, 0, 0, 3'b000);
            step(0, 0, 1, seq[i]);
        end
    endtask

    // Stop with in_valid high (must be ignored), then check done rises LATENCY+1 edges later.
    task automatic stop_and_drain();
        step(0, 1, 1, 3'b101);
        chk("done0_k1", bus0.done, 0);
        chk("done1_k1", bus1.done, 0);
        chk("busy0_k1", bus0.busy, 1);
        for (int k = 2; k <= 6; k++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            chk("done0", bus0.done, k >= LAT0 + 1);
            chk("done1", bus1.done, k >= LAT1 + 1);
            chk("busy0", bus0.busy, k < LAT0 + 1);
            chk("busy1", bus1.busy, k < LAT1 + 1);
        end
    endtask

    initial begin
        seq = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b111, 3'b101, 3'b001};
        for (int k = 0; k < 5; k++) hist[k] = '0;
        drive_idle();
        {bus0.a, bus0.b, bus0.cin, bus0.s, bus0.cout} = '0;
        {bus1.a, bus1.b, bus1.cin, bus1.s, bus1.cout} = '0;
        clear_model();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_results();
        chk("rst_busy0", bus0.busy, 0);
        chk("rst_done0", bus0.done, 0);
        chk("rst_busy1", bus1.busy, 0);
        chk("rst_done1", bus1.done, 0);
        rst = 1'b0;

        // in_valid while IDLE is ignored
        step(0, 0, 1, 3'b111);
        step(0, 0, 1, 3'b110);

        step(1, 0, 0, 3'b000);
        chk("run_busy0", bus0.busy, 1);
        run_seq(0);
        stop_and_drain();
        chk("t1_pass0", bus0.pass_cnt, 8);
        chk("t1_fail0", bus0.fail_cnt, 0);
        chk("t1_cov0", bus0.cov_map, 8'hFF);
        chk("t1_full0", bus0.cov_full, 1);
        chk("t1_err0", bus0.err, 0);
        chk("t1_pass1_sat", bus1.pass_cnt, 7);

        // in_valid while DONE is ignored
        step(0, 0, 1, 3'b011);
        step(0, 0, 1, 3'b001);

        step(1, 0, 0, 3'b000);
        run_seq(1);
        stop_and_drain();
        chk("gap_pass0", bus0.pass_cnt, 8);
        chk("gap_fail0", bus0.fail_cnt, 0);
        chk("gap_pass1", bus1.pass_cnt, 7);

        force_c0 = 1;
        step(1, 0, 0, 3'b000);
        run_seq(0);
        stop_and_drain();
        force_c0 = 0;
        chk("flt_fail0", bus0.fail_cnt, 4);
        chk("flt_pass0", bus0.pass_cnt, 4);
        chk("flt_err0", bus0.err, 1);
        chk("flt_ff0", bus0.first_fail, 5'b11000);
        chk("flt_fail1", bus1.fail_cnt, 4);
        chk("flt_ff1", bus1.first_fail, 5'b11000);

        // start and stop together in DONE with err set: start wins
        step(1, 1, 0, 3'b000);
        chk("ss_busy0", bus0.busy, 1);
        chk("ss_done0", bus0.done, 0);
        chk("ss_err0", bus0.err, 0);
        chk("ss_pass0", bus0.pass_cnt, 0);
        chk("ss_fail0", bus0.fail_cnt, 0);
        chk("ss_ff0", bus0.first_fail, 0);
        chk("ss_cov0", bus0.cov_map, 0);
        step(0, 0, 1, 3'b111);
        repeat (5) step(0, 0, 0, 3'b000);
        chk("ss_run_pass0", bus0.pass_cnt, 1);
        stop_and_drain();

        // async reset mid-RUN with vectors in flight
        step(1, 0, 0, 3'b000);
        step(0, 0, 1, 3'b011);
        step(0, 0, 1, 3'b101);
        step(0, 0, 1, 3'b110);
        chk("pre_rst_pass0", bus0.pass_cnt, 2);
        #2 rst = 1'b1;
        #1;
        clear_model();
        in_run = 0;
        check_results();
        chk("rst_mid_busy0", bus0.busy, 0);
        chk("rst_mid_busy1", bus1.busy, 0);
        step(0, 0, 0, 3'b000);
        step(0, 0, 0, 3'b000);
        rst = 1'b0;
        repeat (6) step(0, 0, 1, 3'b111);
        chk("post_rst_pass0", bus0.pass_cnt, 0);
        chk("post_rst_pass1", bus1.pass_cnt, 0);
        chk("post_rst_done0", bus0.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
